key_move_ctrl: RTL and testbench
================================

# key_move_ctrl

Controller that turns PS/2 keyboard scan codes into movement commands for the on-screen block and sequences position updates to the VGA renderer. Sits between the `ps2` receiver (`key`, `new_code`) and the `vga` display (`xpos`, `ypos`). It decodes make/break/extended prefixes, queues commands, and applies at most one move per video frame with screen-edge clamping.

## Interface
- `SCREEN_W`, 640: visible width in pixels
- `SCREEN_H`, 480: visible height in pixels
- `BLOCK_W`, 32: block width in pixels
- `BLOCK_H`, 32: block height in pixels
- `STEP`, 8: pixels moved per command
- `FIFO_DEPTH`, 4: command queue depth (power of two)

- `clk` in 1: system clock, same domain as `ps2` and `vga`
- `rst` in 1: asynchronous, active-low reset
- `key` in 8: last received scan code byte, valid when `new_code` is high
- `new_code` in 1: single-cycle strobe, one new byte on `key`
- `frame_tick` in 1: single-cycle pulse at start of vertical blanking
- `xpos` out 10: block top-left X
- `ypos` out 10: block top-left Y
- `moved` out 1: single-cycle pulse, position register updated
- `cmd_pending` out 1: command queue non-empty
- `overflow` out 1: sticky, a command was dropped on a full queue

## Operation
- Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Advances only on `new_code`.
  - IDLE: E0 goes to EXT. F0 goes to BRK. A known make code enqueues its command and stays in IDLE. Any other byte stays in IDLE.
  - EXT: F0 goes to EXT_BRK. 75/72/6B/74 enqueue UP/DOWN/LEFT/RIGHT and return to IDLE. Any other byte returns to IDLE with no command.
  - BRK and EXT_BRK: the next byte is consumed with no command and the FSM returns to IDLE.
- Non-extended make codes: 1D→UP, 1B→DOWN, 1C→LEFT, 23→RIGHT, 29 (space)→CENTER.
- Typematic repeats are plain make codes, so each repeat enqueues another command.
- Queue behaviour:
  - FIFO of 3-bit commands.
  - Push on a full queue drops the new command and sets `overflow`. `overflow` clears only on reset.
- Executor:
  - On `frame_tick` with the queue non-empty, pop one command and apply it.
  - On `frame_tick` with the queue empty, do nothing.
- Arithmetic uses unsigned 10-bit values with clamping and no wrap-around:
  - UP: `ypos = ypos >= STEP ? ypos-STEP : 0`
  - DOWN: `ypos = min(ypos+STEP, SCREEN_H-BLOCK_H)`. Compute in 11 bits before the compare.
  - LEFT and RIGHT: same rules on `xpos` with `SCREEN_W-BLOCK_W`.
  - CENTER: `xpos=(SCREEN_W-BLOCK_W)/2`, `ypos=(SCREEN_H-BLOCK_H)/2`.
- `moved` pulses whenever a popped command is applied, including clamped no-ops. A clamped no-op leaves the value unchanged but still pulses `moved`.
- Reset values:
  - Decoder in IDLE, queue empty.
  - `xpos=304`, `ypos=224` (defaults), `moved=0`, `cmd_pending=0`, `overflow=0`.

## Timing
- Byte to queue: the command is written at the clock edge where `new_code` is sampled high. `cmd_pending` is high the following cycle.
- Pop and move: when `frame_tick` is sampled high, `xpos`/`ypos` and `moved` update at that same edge. Latency is 1 cycle from `frame_tick` to new outputs.
- Same-cycle push and pop:
  - Both occur and the count is unchanged.
  - With a full queue this is not an overflow.
  - With an empty queue the pop sees empty: no bypass, and the new command executes on the next `frame_tick`.
- Maximum move rate is one per frame. Excess keypresses accumulate up to `FIFO_DEPTH`.
- Reset assertion mid-frame or mid-sequence clears all state immediately. A byte sequence interrupted by reset is treated as new from IDLE.
- Outputs are registered. `new_code` and `frame_tick` are assumed to be synchronous to `clk`.

## Structure
- Package `key_move_pkg`:
  - Command encoding: NONE, UP, DOWN, LEFT, RIGHT, CENTER.
  - Scan-code constants: E0, F0, 75, 72, 6B, 74, 1D, 1B, 1C, 23, 29.
  - Decoder state type.
- Sub-module `cmd_fifo`, parameterised by width and depth:
  - Ports: push, pop, din, dout, full, empty.
  - Synchronous read with first-word fall-through, so the command is valid on `dout` while not empty.
- Top contains the decoder FSM and the position executor.

## Test plan
- Reset, then stimulus byte 1D with one `frame_tick` → `xpos=304`, `ypos=216`, one `moved` pulse.
- Bytes E0 74 then E0 F0 74, two `frame_tick`s → one RIGHT only: `xpos=312` after the first tick, no change and no `moved` on the second.
- 40 × E0 6B (LEFT) spaced across frames, with 40 ticks → `xpos` clamps at 0, `moved` pulses 40 times.
- Six make codes with no `frame_tick` → four queued, `overflow=1`. Four ticks then drain them and `cmd_pending=0`.
- DOWN pushed in the same cycle as `frame_tick` on an empty queue → no move on that tick, move on the next tick (`ypos=232`).
- Sequence E0 F0, `rst` low for 2 cycles, then 75 → no command (IDLE treats 75 as unknown), positions back at 304/224.

Source files
------------

// File: rtl/key_move_pkg.sv
// Shared types and constants for the keyboard-driven block mover:
// command encoding, PS/2 scan codes and the decoder state type.
package key_move_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE   = 3'd0,
        CMD_UP     = 3'd1,
        CMD_DOWN   = 3'd2,
        CMD_LEFT   = 3'd3,
        CMD_RIGHT  = 3'd4,
        CMD_CENTER = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Prefix bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    // Extended (arrow) make codes
    localparam logic [7:0] SC_EUP    = 8'h75;
    localparam logic [7:0] SC_EDOWN  = 8'h72;
    localparam logic [7:0] SC_ELEFT  = 8'h6B;
    localparam logic [7:0] SC_ERIGHT = 8'h74;
    // Plain make codes (W/S/A/D style keys and space)
    localparam logic [7:0] SC_UP     = 8'h1D;
    localparam logic [7:0] SC_DOWN   = 8'h1B;
    localparam logic [7:0] SC_LEFT   = 8'h1C;
    localparam logic [7:0] SC_RIGHT  = 8'h23;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    // Command for a non-extended make code, NONE if unrecognised
    function automatic cmd_e plain_make(input logic [7:0] k);
        case (k)
            SC_UP:    return CMD_UP;
            SC_DOWN:  return CMD_DOWN;
            SC_LEFT:  return CMD_LEFT;
            SC_RIGHT: return CMD_RIGHT;
            SC_SPACE: return CMD_CENTER;
            default:  return CMD_NONE;
        endcase
    endfunction

    // Command for an E0-prefixed make code, NONE if unrecognised
    function automatic cmd_e ext_make(input logic [7:0] k);
        case (k)
            SC_EUP:    return CMD_UP;
            SC_EDOWN:  return CMD_DOWN;
            SC_ELEFT:  return CMD_LEFT;
            SC_ERIGHT: return CMD_RIGHT;
            default:   return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small first-word-fall-through FIFO. The head entry is visible on dout
// whenever the queue is non-empty. A pop on an empty queue is ignored, and
// a push on a full queue only lands if a pop frees a slot that same cycle.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when low bits match
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents are don't-care while the slot is free
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/key_move_ctrl.sv
// Turns PS/2 scan bytes into block movement commands, queues them, and
// applies at most one queued command per video frame with edge clamping.
module key_move_ctrl
    import key_move_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BLOCK_W    = 32,
    parameter int BLOCK_H    = 32,
    parameter int STEP       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       new_code,
    input  logic       frame_tick,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       moved,
    output logic       cmd_pending,
    output logic       overflow
);

    localparam logic [9:0]  P_STEP   = 10'(STEP);
    localparam logic [10:0] P_STEP11 = 11'(STEP);
    localparam logic [10:0] P_XMAX   = 11'(SCREEN_W - BLOCK_W);
    localparam logic [10:0] P_YMAX   = 11'(SCREEN_H - BLOCK_H);
    localparam logic [9:0]  P_XCTR   = 10'((SCREEN_W - BLOCK_W) / 2);
    localparam logic [9:0]  P_YCTR   = 10'((SCREEN_H - BLOCK_H) / 2);

    dec_state_e       r_state;
    dec_state_e       w_next;
    cmd_e             w_cmd;
    logic             w_push;
    logic             w_pop;
    logic [CMD_W-1:0] w_dout;
    cmd_e             w_head;
    logic             w_full;
    logic             w_empty;
    logic [10:0]      w_x_inc;
    logic [10:0]      w_y_inc;
    logic [9:0]       r_xpos;
    logic [9:0]       r_ypos;
    logic             r_moved;
    logic             r_overflow;

    // ---------------- Decoder FSM ----------------

    // Decoder state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Decoder next state; only a received byte moves the FSM
    always_comb begin
        w_next = r_state;
        if (new_code) begin
            case (r_state)
                ST_IDLE: begin
                    if (key == SC_EXT)      w_next = ST_EXT;
                    else if (key == SC_BRK) w_next = ST_BRK;
                    else                    w_next = ST_IDLE;
                end
                ST_EXT: begin
                    if (key == SC_BRK) w_next = ST_EXT_BRK;
                    else               w_next = ST_IDLE;
                end
                // Byte after a break prefix is the released key: swallow it
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Decoder output: command to enqueue for the byte arriving this cycle
    always_comb begin
        w_cmd = CMD_NONE;
        if (new_code) begin
            case (r_state)
                ST_IDLE: w_cmd = plain_make(key);
                ST_EXT:  w_cmd = ext_make(key);
                default: w_cmd = CMD_NONE;
            endcase
        end
        w_push = (w_cmd != CMD_NONE);
    end

    // ---------------- Command queue ----------------

    // Pop is requested every frame; the FIFO ignores it while empty, so a
    // command pushed on the same tick is not bypassed to the executor.
    assign w_pop  = frame_tick;
    assign w_head = cmd_e'(w_dout);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_cmd),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Sticky drop flag: full queue with no pop freeing a slot this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                            r_overflow <= 1'b0;
        else if (w_push && w_full && !(w_pop && !w_empty))   r_overflow <= 1'b1;
    end

    // ---------------- Position executor ----------------

    // Widened sums so the clamp compare cannot be fooled by 10-bit wrap
    assign w_x_inc = {1'b0, r_xpos} + P_STEP11;
    assign w_y_inc = {1'b0, r_ypos} + P_STEP11;

    // Apply the queue head on a frame tick; clamped no-ops still pulse moved
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xpos  <= P_XCTR;
            r_ypos  <= P_YCTR;
            r_moved <= 1'b0;
        end else begin
            r_moved <= 1'b0;
            if (frame_tick && !w_empty) begin
                r_moved <= 1'b1;
                case (w_head)
                    CMD_UP:     r_ypos <= (r_ypos >= P_STEP) ? r_ypos - P_STEP : 10'd0;
                    CMD_DOWN:   r_ypos <= (w_y_inc > P_YMAX) ? P_YMAX[9:0] : w_y_inc[9:0];
                    CMD_LEFT:   r_xpos <= (r_xpos >= P_STEP) ? r_xpos - P_STEP : 10'd0;
                    CMD_RIGHT:  r_xpos <= (w_x_inc > P_XMAX) ? P_XMAX[9:0] : w_x_inc[9:0];
                    CMD_CENTER: begin
                        r_xpos <= P_XCTR;
                        r_ypos <= P_YCTR;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign moved       = r_moved;
    assign cmd_pending = !w_empty;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_move_ctrl.sv
// Bench for key_move_ctrl: directed scenarios followed by random byte/tick
// traffic, every cycle compared against a queue-based reference model.
module tb_key_move_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key;
    logic       new_code;
    logic       frame_tick;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       moved;
    logic       cmd_pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int n_moved  = 0;

    key_move_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .new_code    (new_code),
        .frame_tick  (frame_tick),
        .xpos        (xpos),
        .ypos        (ypos),
        .moved       (moved),
        .cmd_pending (cmd_pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: commands are plain ints (1 up,2 down,3 left,4 right,5 centre)
    int q[$];
    int mx, my;
    bit m_ovf, m_moved, m_ext, m_brk;

    function automatic int plain_of(input logic [7:0] k);
        case (k)
            8'h1D: return 1;
            8'h1B: return 2;
            8'h1C: return 3;
            8'h23: return 4;
            8'h29: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int ext_of(input logic [7:0] k);
        case (k)
            8'h75: return 1;
            8'h72: return 2;
            8'h6B: return 3;
            8'h74: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        mx = 304; my = 224;
        m_ovf = 0; m_moved = 0; m_ext = 0; m_brk = 0;
    endtask

    task automatic model_edge(input bit nc, input logic [7:0] k, input bit tk);
        int c;
        int h;
        c = 0;
        m_moved = 0;
        // Pop decision uses queue contents before this cycle's push
        if (tk && q.size() > 0) begin
            h = q.pop_front();
            m_moved = 1;
            case (h)
                1: my = (my >= 8) ? my - 8 : 0;
                2: my = (my + 8 > 448) ? 448 : my + 8;
                3: mx = (mx >= 8) ? mx - 8 : 0;
                4: mx = (mx + 8 > 608) ? 608 : mx + 8;
                5: begin mx = 304; my = 224; end
                default: ;
            endcase
        end
        if (nc) begin
            if (m_brk) begin
                m_brk = 0; m_ext = 0;
            end else if (k == 8'hF0) begin
                m_brk = 1;
            end else if (m_ext) begin
                c = ext_of(k); m_ext = 0;
            end else if (k == 8'hE0) begin
                m_ext = 1;
            end else begin
                c = plain_of(k);
            end
        end
        if (c != 0) begin
            if (q.size() < 4) q.push_back(c);
            else              m_ovf = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".xpos"},    {22'd0, xpos},        mx);
        check({tag, ".ypos"},    {22'd0, ypos},        my);
        check({tag, ".moved"},   {31'd0, moved},       {31'd0, m_moved});
        check({tag, ".pending"}, {31'd0, cmd_pending}, (q.size() > 0) ? 32'd1 : 32'd0);
        check({tag, ".ovf"},     {31'd0, overflow},    {31'd0, m_ovf});
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge
    task automatic step(input string tag, input bit nc, input logic [7:0] k, input bit tk);
        new_code = nc; key = k; frame_tick = tk;
        model_edge(nc, k, tk);
        @(posedge clk); #1;
        new_code = 1'b0; frame_tick = 1'b0;
        if (moved === 1'b1) n_moved++;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                              8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'hE0, 8'hF0, 8'h00};

    initial begin
        logic [7:0] rk;
        rst = 1'b0; key = 8'h00; new_code = 1'b0; frame_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Plain UP then one tick
        step("up_push", 1, 8'h1D, 0);
        step("up_tick", 0, 8'h00, 1);
        check("tp1.y", {22'd0, ypos}, 216);

        // Extended RIGHT make, then its break: only one command
        step("er_e0",  1, 8'hE0, 0);
        step("er_74",  1, 8'h74, 0);
        step("eb_e0",  1, 8'hE0, 0);
        step("eb_f0",  1, 8'hF0, 0);
        step("eb_74",  1, 8'h74, 0);
        step("er_t1",  0, 8'h00, 1);
        check("tp2.x", {22'd0, xpos}, 312);
        step("er_t2",  0, 8'h00, 1);
        check("tp2.nomove", {31'd0, moved}, 0);

        // 40 extended LEFTs, one per frame: clamps at 0
        n_moved = 0;
        for (int i = 0; i < 40; i++) begin
            step("l_e0", 1, 8'hE0, 0);
            step("l_6b", 1, 8'h6B, 0);
            step("l_tk", 0, 8'h00, 1);
        end
        check("tp3.x", {22'd0, xpos}, 0);
        check("tp3.moves", n_moved, 40);

        // Six makes with no tick: four queued, overflow set
        for (int i = 0; i < 6; i++) step("ov_push", 1, 8'h1B, 0);
        check("tp4.ovf", {31'd0, overflow}, 1);
        for (int i = 0; i < 4; i++) step("ov_drain", 0, 8'h00, 1);
        check("tp4.pend", {31'd0, cmd_pending}, 0);

        // Full queue: push with a simultaneous pop is not a drop
        do_reset("rst_a");
        for (int i = 0; i < 4; i++) step("fp_push", 1, 8'h23, 0);
        step("fp_both", 1, 8'h1C, 1);
        check("full_pp.ovf", {31'd0, overflow}, 0);
        for (int i = 0; i < 4; i++) step("fp_drain", 0, 8'h00, 1);

        // Push on same tick as empty pop: executes on the next tick
        do_reset("rst_b");
        step("sp_both", 1, 8'h1B, 1);
        check("tp5.nomove", {31'd0, moved}, 0);
        step("sp_tick", 0, 8'h00, 1);
        check("tp5.y", {22'd0, ypos}, 232);

        // Reset mid break sequence: 75 afterwards is unknown in IDLE
        step("rb_e0", 1, 8'hE0, 0);
        step("rb_f0", 1, 8'hF0, 0);
        do_reset("rst_c");
        step("rb_75", 1, 8'h75, 0);
        step("rb_tk", 0, 8'h00, 1);
        check("tp6.pend", {31'd0, cmd_pending}, 0);
        check("tp6.y", {22'd0, ypos}, 224);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
            rk = pool[$urandom_range(0, 13)];
            if (rk == 8'h00) rk = 8'($urandom);
            step("rnd", ($urandom_range(0, 9) < 4), rk, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
